// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - software-triggered gate window and event counter for the frequency counter
// Optional FREQ_GATE_AUTO_EN: re-arm a new window straight after every LATCH cycle.
module freq_gate_ctrl #(
  parameter int GATE_W = 16,
  parameter int CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              edge_pulse,
  output logic              busy,
  output logic              gate_open,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GATE  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [GATE_W-1:0] len_q;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf_q;
  logic              launch;
  logic              arm;
  logic              gate_end;
  logic              cnt_full;

  assign busy     = (state != ST_IDLE);
  assign cnt_full = &edge_cnt;
  assign gate_end = (gate_cnt == len_q);

`ifdef FREQ_GATE_AUTO_EN
  assign launch = ((state == ST_IDLE) && start) || (state == ST_LATCH);
`else
  assign launch = (state == ST_IDLE) && start;
`endif

  // abort wins over a fresh launch, including start in IDLE and the auto re-arm
  assign arm = launch && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      gate_cnt     <= '0;
      edge_cnt     <= '0;
      ovf_q        <= 1'b0;
      gate_open    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (abort && busy) begin
        state     <= ST_IDLE;
        gate_open <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_GATE: begin
            // the strobe on the closing edge still belongs to this window
            if (edge_pulse) begin
              if (cnt_full) ovf_q <= 1'b1;
              else          edge_cnt <= edge_cnt + CNT_ONE;
            end
            if (gate_end) begin
              state     <= ST_LATCH;
              gate_open <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + GATE_ONE;
            end
          end
          ST_LATCH: begin
            result       <= edge_cnt;
            overflow     <= ovf_q;
            result_valid <= 1'b1;
            state        <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
        if (arm) begin
          state     <= ST_GATE;
          len_q     <= gate_len;
          gate_cnt  <= '0;
          edge_cnt  <= '0;
          ovf_q     <= 1'b0;
          gate_open <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - directed self-checking bench for freq_gate_ctrl
// A second instance with CNT_W=4 covers counter saturation.
module tb_freq_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] gate_len;
  logic        edge_pulse;
  logic        busy, gate_open, result_valid, overflow;
  logic [23:0] result;
  logic        busy_s, gate_open_s, result_valid_s, overflow_s;
  logic [3:0]  result_s;

  int checks = 0;
  int errors = 0;
  int obs_go, obs_rv, obs_rv_at, obs_busy_low, obs_rv_s;

  always #5 clk = ~clk;

  freq_gate_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .edge_pulse(edge_pulse), .busy(busy), .gate_open(gate_open), .result(result),
    .result_valid(result_valid), .overflow(overflow)
  );

  freq_gate_ctrl #(.GATE_W(16), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_len(gate_len),
    .edge_pulse(edge_pulse), .busy(busy_s), .gate_open(gate_open_s), .result(result_s),
    .result_valid(result_valid_s), .overflow(overflow_s)
  );

  // mask[j] is edge_pulse at edge T0+j; k indexes the sample taken just after edge T0+k
  task automatic do_run(input int len, input logic [63:0] mask, input int restart_at, input int abort_at);
    obs_go = 0; obs_rv = 0; obs_rv_at = -1; obs_busy_low = -1; obs_rv_s = 0;
    gate_len = len[15:0]; start = 1'b1; abort = 1'b0; edge_pulse = mask[0];
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      if (gate_open) obs_go++;
      if (result_valid) begin obs_rv++; obs_rv_at = k; end
      if (result_valid_s) obs_rv_s++;
      if (!busy && obs_busy_low < 0) obs_busy_low = k;
      start = (k + 1 == restart_at);
      abort = (k + 1 == abort_at);
      edge_pulse = mask[k + 1];
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; edge_pulse = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gate_len = '0; edge_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL reset_gate_open got %b exp 0", gate_open); end
    checks++; if (result !== 24'd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifndef FREQ_GATE_AUTO_EN
  task automatic test_basic;
    do_run(9, {64{1'b1}}, -1, -1);
    checks++; if (obs_go !== 10) begin errors++; $display("FAIL basic_gate_cycles got %0d exp 10", obs_go); end
    checks++; if (obs_rv !== 1) begin errors++; $display("FAIL basic_valid_count got %0d exp 1", obs_rv); end
    checks++; if (obs_rv_at !== 11) begin errors++; $display("FAIL basic_valid_at got %0d exp 11", obs_rv_at); end
    checks++; if (obs_busy_low !== 11) begin errors++; $display("FAIL basic_busy_low got %0d exp 11", obs_busy_low); end
    checks++; if (result !== 24'd10) begin errors++; $display("FAIL basic_result got %0d exp 10", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_len_zero;
    do_run(0, 64'h2, -1, -1);
    checks++; if (obs_go !== 1) begin errors++; $display("FAIL len0_gate_cycles got %0d exp 1", obs_go); end
    checks++; if (obs_rv_at !== 2) begin errors++; $display("FAIL len0_valid_at got %0d exp 2", obs_rv_at); end
    checks++; if (result !== 24'd1) begin errors++; $display("FAIL len0_in_window got %0d exp 1", result); end
    do_run(0, 64'h4, -1, -1);
    checks++; if (obs_rv !== 1) begin errors++; $display("FAIL len0_latch_valid got %0d exp 1", obs_rv); end
    checks++; if (result !== 24'd0) begin errors++; $display("FAIL len0_latch_ignored got %0d exp 0", result); end
  endtask

  task automatic test_saturation;
    do_run(19, {64{1'b1}}, -1, -1);
    checks++; if (result_s !== 4'd15) begin errors++; $display("FAIL sat_result got %0d exp 15", result_s); end
    checks++; if (overflow_s !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b exp 1", overflow_s); end
    checks++; if (obs_rv_s !== 1) begin errors++; $display("FAIL sat_valid got %0d exp 1", obs_rv_s); end
    checks++; if (result !== 24'd20) begin errors++; $display("FAIL wide_result got %0d exp 20", result); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wide_overflow got %b exp 0", overflow); end
    do_run(19, 64'hE, -1, -1);
    checks++; if (result_s !== 4'd3) begin errors++; $display("FAIL sat_next_result got %0d exp 3", result_s); end
    checks++; if (overflow_s !== 1'b0) begin errors++; $display("FAIL sat_next_overflow got %b exp 0", overflow_s); end
  endtask

  task automatic test_abort;
    do_run(9, {64{1'b1}}, -1, 5);
    checks++; if (obs_busy_low !== 5) begin errors++; $display("FAIL abort_busy_low got %0d exp 5", obs_busy_low); end
    checks++; if (obs_go !== 5) begin errors++; $display("FAIL abort_gate_cycles got %0d exp 5", obs_go); end
    checks++; if (obs_rv !== 0) begin errors++; $display("FAIL abort_valid got %0d exp 0", obs_rv); end
    checks++; if (result !== 24'd3) begin errors++; $display("FAIL abort_result_kept got %0d exp 3", result); end
    start = 1'b1; abort = 1'b1; gate_len = 16'd9;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy got %b exp 0", busy); end
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL start_abort_gate got %b exp 0", gate_open); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_start;
    do_run(9, {64{1'b1}}, 4, -1);
    checks++; if (obs_rv !== 1) begin errors++; $display("FAIL busy_start_valid got %0d exp 1", obs_rv); end
    checks++; if (obs_go !== 10) begin errors++; $display("FAIL busy_start_gate got %0d exp 10", obs_go); end
    checks++; if (result !== 24'd10) begin errors++; $display("FAIL busy_start_result got %0d exp 10", result); end
  endtask

  task automatic test_back_to_back;
    do_run(2, {64{1'b1}}, 5, -1);
    checks++; if (obs_rv !== 2) begin errors++; $display("FAIL b2b_valid got %0d exp 2", obs_rv); end
    checks++; if (obs_rv_at !== 9) begin errors++; $display("FAIL b2b_valid_at got %0d exp 9", obs_rv_at); end
    checks++; if (obs_go !== 6) begin errors++; $display("FAIL b2b_gate got %0d exp 6", obs_go); end
    checks++; if (result !== 24'd3) begin errors++; $display("FAIL b2b_result got %0d exp 3", result); end
    do_run(2, {64{1'b1}}, 4, -1);
    checks++; if (obs_rv !== 1) begin errors++; $display("FAIL latch_start_valid got %0d exp 1", obs_rv); end
    checks++; if (obs_go !== 3) begin errors++; $display("FAIL latch_start_gate got %0d exp 3", obs_go); end
  endtask

  task automatic test_reset_mid;
    gate_len = 16'd9; start = 1'b1; edge_pulse = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", busy); end
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL mid_reset_gate got %b exp 0", gate_open); end
    checks++; if (result !== 24'd0) begin errors++; $display("FAIL mid_reset_result got %0d exp 0", result); end
    edge_pulse = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
`else
  task automatic test_auto;
    do_run(4, {64{1'b1}}, -1, 20);
    checks++; if (obs_rv !== 3) begin errors++; $display("FAIL auto_valid_count got %0d exp 3", obs_rv); end
    checks++; if (obs_rv_at !== 18) begin errors++; $display("FAIL auto_last_valid got %0d exp 18", obs_rv_at); end
    checks++; if (obs_go !== 17) begin errors++; $display("FAIL auto_gate got %0d exp 17", obs_go); end
    checks++; if (obs_busy_low !== 20) begin errors++; $display("FAIL auto_busy_low got %0d exp 20", obs_busy_low); end
    checks++; if (result !== 24'd5) begin errors++; $display("FAIL auto_result got %0d exp 5", result); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef FREQ_GATE_AUTO_EN
    test_basic();
    test_len_zero();
    test_saturation();
    test_abort();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
`else
    test_auto();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
